sim_run_engine: RTL and testbench
=================================

SIM_RUN_ENGINE -- requirements
Module: sim_run_engine

Interface
REQ-001 The module SHALL have parameter MAX_STEPS, default 1000, meaning the maximum number of draws per run (16-bit range, 1..65535).
REQ-002 The module SHALL have port clk  input  1  system clock, all state changes on rising edge.
REQ-003 The module SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 The module SHALL have port start  input  1  run request, sampled only in IDLE.
REQ-005 The module SHALL have port seed  input  23  LFSR seed for the run.
REQ-006 The module SHALL have ports qa and qb, each input  8, initial ask and bid queue sizes.
REQ-007 The module SHALL have ports mu_a and mu_b, each input  8, per-draw depletion thresholds for ask and bid.
REQ-008 The module SHALL have port busy  output  1  high in RUN and DONE.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse marking run completion.
REQ-010 The module SHALL have port y  output  1  run outcome, 1 = ask depleted first (price up).
REQ-011 The design SHALL use one clock (clk); reset rst SHALL be asynchronous and active-high.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, DONE.
REQ-013 In IDLE, start=1 at an edge SHALL load lfsr=seed, ask_q=qa, bid_q=qb, steps=0, clear y, and enter RUN.
REQ-014 If seed==0, the engine SHALL load lfsr=1.
REQ-015 The inputs qa, qb, mu_a, mu_b and seed SHALL be sampled only at load; later changes SHALL have no effect on the current run.
REQ-016 The LFSR SHALL be 23-bit Fibonacci, next = {lfsr[21:0], lfsr[22]^lfsr[17]}.
REQ-017 At each RUN edge, if ask_q==0, bid_q==0 or steps==MAX_STEPS, the FSM SHALL enter DONE.
- Terminating edge: y = (ask_q==0 && bid_q!=0).
- No draw is performed on the terminating edge.
REQ-018 Otherwise, each RUN edge SHALL perform one draw using the current lfsr.
- ask_q decrements if lfsr[7:0] < mu_a.
- bid_q decrements independently if lfsr[15:8] < mu_b.
- steps increments; lfsr advances.
REQ-019 Both queues SHALL be able to decrement on the same draw; simultaneous zero is a tie, and a tie SHALL give y=0.
REQ-020 Timeout (steps==MAX_STEPS with both queues nonzero) SHALL give y=0.
REQ-021 The done output SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE on the next edge.
REQ-022 The y output SHALL be valid while done is high and SHALL be held until the next load or reset.
REQ-023 A start sampled in RUN or DONE SHALL be ignored; it SHALL neither queue nor restart the run.
REQ-024 Latency: with start sampled at edge k and D draws performed, done SHALL rise at edge k+D+1.
REQ-025 Counters SHALL never wrap: queues decrement only when nonzero, and steps never exceeds MAX_STEPS.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, done=0, y=0, busy=0, lfsr=1, ask_q=0, bid_q=0, steps=0, regardless of clk.
REQ-027 A reset mid-run SHALL abort the run with no done pulse; the first start after deassertion SHALL begin a clean run.

Configuration
REQ-028 With SIM_STEP_COUNT_EN defined, the module SHALL add port steps_out  output  16, equal to steps, registered, valid with done and held until the next load; it resets to 0.
REQ-029 Without SIM_STEP_COUNT_EN, the steps_out port and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Scenario: qa=0, qb=5, start at edge k -> done at edge k+1, y=1, steps_out=0.
REQ-031 Scenario: qa=0, qb=0 -> done at edge k+1, y=0 (tie).
REQ-032 Scenario: mu_a=0, mu_b=0, qa=qb=3, MAX_STEPS=10 -> done at edge k+11, y=0, steps_out=10.
REQ-033 Scenario: mu_a=255, mu_b=0, qa=1, qb=200, seed=1 -> y=1 within 2 draws; repeating the run with seed=0 gives an identical done cycle and y.
REQ-034 Scenario: start pulsed again mid-run -> ignored; exactly one done pulse occurs at the original predicted edge.
REQ-035 Scenario: rst asserted asynchronously mid-run -> busy=0 and done=0 immediately; a following start with qa=0 gives done one edge later with y=1.

Source files
------------

// File: rtl/sim_run_engine.sv
`default_nettype none
// ============================================================================
// sim_run_engine : LFSR-driven race between ask/bid queue depletion.
// Optional SIM_STEP_COUNT_EN adds a registered steps_out port.  Rev 1.0
// ============================================================================
module sim_run_engine #(
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [22:0] seed,
  input  logic [7:0]  qa,
  input  logic [7:0]  qb,
  input  logic [7:0]  mu_a,
  input  logic [7:0]  mu_b,
  output logic        busy,
  output logic        done,
  output logic        y
`ifdef SIM_STEP_COUNT_EN
  ,
  output logic [15:0] steps_out
`endif
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [22:0] lfsr;
  logic [7:0]  ask_q;
  logic [7:0]  bid_q;
  logic [7:0]  mu_a_r;
  logic [7:0]  mu_b_r;
  logic [15:0] steps;

  logic [22:0] lfsr_next;
  logic        terminate;
  logic        dec_a;
  logic        dec_b;

  assign lfsr_next = {lfsr[21:0], lfsr[22] ^ lfsr[17]};
  assign terminate = (ask_q == 8'd0) || (bid_q == 8'd0) || (steps == MAX_CNT);
  // Queues only move when nonzero so they can never wrap.
  assign dec_a     = (lfsr[7:0]  < mu_a_r) && (ask_q != 8'd0);
  assign dec_b     = (lfsr[15:8] < mu_b_r) && (bid_q != 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= 23'd1;
      ask_q     <= 8'd0;
      bid_q     <= 8'd0;
      mu_a_r    <= 8'd0;
      mu_b_r    <= 8'd0;
      steps     <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= 1'b0;
`ifdef SIM_STEP_COUNT_EN
      steps_out <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lfsr      <= (seed == 23'd0) ? 23'd1 : seed;
            ask_q     <= qa;
            bid_q     <= qb;
            mu_a_r    <= mu_a;
            mu_b_r    <= mu_b;
            steps     <= 16'd0;
            y         <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
`ifdef SIM_STEP_COUNT_EN
            steps_out <= 16'd0;
`endif
          end
        end
        RUN: begin
          if (terminate) begin
            // A tie or a timeout leaves ask_q nonzero or bid_q zero, so y=0.
            y         <= (ask_q == 8'd0) && (bid_q != 8'd0);
            done      <= 1'b1;
            state     <= DONE;
`ifdef SIM_STEP_COUNT_EN
            steps_out <= steps;
`endif
          end else begin
            if (dec_a) ask_q <= ask_q - 8'd1;
            if (dec_b) bid_q <= bid_q - 8'd1;
            steps <= steps + 16'd1;
            lfsr  <= lfsr_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sim_run_engine.sv
`default_nettype none
// ============================================================================
// tb_sim_run_engine : randomized self-checking bench against a run-level model.
// Rev 1.0
// ============================================================================
module tb_sim_run_engine;

  localparam int MAXS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [22:0] seed;
  logic [7:0]  qa, qb, mu_a, mu_b;
  logic        busy, done, y;
`ifdef SIM_STEP_COUNT_EN
  logic [15:0] steps_out;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  sim_run_engine #(.MAX_STEPS(MAXS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seed  (seed),
    .qa    (qa),
    .qb    (qb),
    .mu_a  (mu_a),
    .mu_b  (mu_b),
    .busy  (busy),
    .done  (done),
    .y     (y)
`ifdef SIM_STEP_COUNT_EN
    ,
    .steps_out (steps_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Whole-run outcome: number of draws and final y, straight from the draw rules.
  function automatic void model(input logic [22:0] s, input int a0, input int b0,
                                input int ma, input int mb, output int d, output bit yy);
    int a = a0, b = b0;
    logic [22:0] l = (s == 23'd0) ? 23'd1 : s;
    d = 0;
    while (a != 0 && b != 0 && d != MAXS) begin
      if (int'(l[7:0])  < ma) a--;
      if (int'(l[15:8]) < mb) b--;
      d++;
      l = {l[21:0], l[22] ^ l[17]};
    end
    yy = (a == 0 && b != 0);
  endfunction

  task automatic do_run(input string tag, input logic [22:0] s, input int a, input int b,
                        input int ma, input int mb, input bit restart_mid);
    int  d, done_edge, done_cnt;
    bit  ey;
    model(s, a, b, ma, mb, d, ey);
    @(negedge clk);
    seed = s; qa = 8'(a); qb = 8'(b); mu_a = 8'(ma); mu_b = 8'(mb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_load"}, busy, 1'b1);
    check({tag, "_y_clear"}, y, 1'b0);
    // Inputs changed after load must not influence the run.
    seed = 23'($urandom); qa = 8'($urandom); qb = 8'($urandom);
    mu_a = 8'($urandom);  mu_b = 8'($urandom);
    done_edge = -1; done_cnt = 0;
    for (int n = 1; n <= MAXS + 5; n++) begin
      @(posedge clk); #1;
      if (restart_mid && n == 1) start = 1'b1;
      if (restart_mid && n == 2) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_edge = n;
        check({tag, "_y"}, y, ey);
`ifdef SIM_STEP_COUNT_EN
        check({tag, "_steps_out"}, steps_out, d);
`endif
      end
    end
    check({tag, "_done_edge"}, done_edge, d + 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_y_hold"}, y, ey);
  endtask

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; seed = '0; qa = '0; qb = '0; mu_a = '0; mu_b = '0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_y", y, 1'b0);
    @(negedge clk); rst = 1'b0;

    do_run("ask_empty", 23'd77, 0, 5, 100, 100, 1'b0);
    do_run("tie_empty", 23'd77, 0, 0, 100, 100, 1'b0);
    do_run("timeout", 23'd5, 3, 3, 0, 0, 1'b0);
    do_run("seed1", 23'd1, 1, 200, 255, 0, 1'b0);
    do_run("seed0", 23'd0, 1, 200, 255, 0, 1'b0);
    do_run("restart_mid", 23'h1234, 6, 6, 40, 40, 1'b1);
    do_run("restart_d0", 23'h1234, 0, 6, 40, 40, 1'b1);

    for (int i = 0; i < 20; i++)
      do_run("rand", 23'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    seed = 23'd9; qa = 8'd5; qb = 8'd5; mu_a = 8'd0; mu_b = 8'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_y", y, 1'b0);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int n = 0; n < MAXS + 3; n++) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("arst_no_done", nd, 0);
    do_run("post_rst", 23'd3, 0, 4, 10, 10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
